// File: rtl/yuv_pkg.sv
// Shared constants and helpers for the YCbCr <-> RGB conversion blocks.
package yuv_pkg;

  // YCbCr -> RGB coefficients, scaled by 256
  localparam int K_RV = 359;
  localparam int K_GU = 88;
  localparam int K_GV = 183;
  localparam int K_BU = 454;

  // RGB -> YCbCr coefficients used by the read-path converter, scaled by 256
  localparam int K_YR = 77;
  localparam int K_YG = 150;
  localparam int K_YB = 29;
  localparam int K_UR = 43;
  localparam int K_UG = 85;
  localparam int K_UB = 128;
  localparam int K_VR = 128;
  localparam int K_VG = 107;
  localparam int K_VB = 21;

  // Chroma pairing state for 4:2:2 streams
  typedef enum logic {PAIR_EVEN, PAIR_ODD} pair_state_t;

  // Chroma zero point for a given component width
  function automatic int yuv_off(input int bpc);
    return 1 << (bpc - 1);
  endfunction

  // Saturate a signed value into the unsigned component range
  function automatic int yuv_clamp(input int val, input int bpc);
    int top;
    top = (1 << bpc) - 1;
    if (val < 0)
      return 0;
    else if (val > top)
      return top;
    else
      return val;
  endfunction

endpackage

// File: rtl/yuv422_pair.sv
// Re-pairs alternating Cb/Cr of a 4:2:2 stream into full pixels.
// Pixel 0 of a pair is issued the cycle after its Cr arrives, pixel 1 the
// cycle after that; a line that ends on an unpaired Y0 is flushed with
// neutral Cr when the next SOL shows up.
module yuv422_pair
  import yuv_pkg::*;
#(
  parameter int C_BPC = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pix_valid,
  input  logic             pix_sol,
  input  logic [C_BPC-1:0] pix_y,
  input  logic [C_BPC-1:0] pix_c,
  output logic             pair_valid,
  output logic             pair_sol,
  output logic [C_BPC-1:0] pair_y,
  output logic [C_BPC-1:0] pair_u,
  output logic [C_BPC-1:0] pair_v
);

  localparam logic [C_BPC-1:0] OFF = C_BPC'(yuv_off(C_BPC));

  pair_state_t      state;
  logic [C_BPC-1:0] y0, cb;
  logic             sol0;
  logic             pend;
  logic [C_BPC-1:0] y1, cb1, cr1;

  // Pairing FSM with registered issue outputs and the pending second pixel
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= PAIR_EVEN;
      y0         <= '0;
      cb         <= '0;
      sol0       <= 1'b0;
      pend       <= 1'b0;
      y1         <= '0;
      cb1        <= '0;
      cr1        <= '0;
      pair_valid <= 1'b0;
      pair_sol   <= 1'b0;
      pair_y     <= '0;
      pair_u     <= '0;
      pair_v     <= '0;
    end else begin
      pair_valid <= 1'b0;
      pair_sol   <= 1'b0;
      // pend implies state is EVEN, so this never competes with a pixel-0 issue
      if (pend) begin
        pair_valid <= 1'b1;
        pair_y     <= y1;
        pair_u     <= cb1;
        pair_v     <= cr1;
        pend       <= 1'b0;
      end
      if (pix_valid) begin
        case (state)
          PAIR_EVEN: begin
            y0    <= pix_y;
            cb    <= pix_c;
            sol0  <= pix_sol;
            state <= PAIR_ODD;
          end
          PAIR_ODD: begin
            pair_valid <= 1'b1;
            pair_sol   <= sol0;
            pair_y     <= y0;
            pair_u     <= cb;
            if (pix_sol) begin
              // odd-length line: flush held Y0 with neutral Cr, start new line
              pair_v <= OFF;
              y0     <= pix_y;
              cb     <= pix_c;
              sol0   <= 1'b1;
            end else begin
              pair_v <= pix_c;
              pend   <= 1'b1;
              y1     <= pix_y;
              cb1    <= cb;
              cr1    <= pix_c;
              state  <= PAIR_EVEN;
            end
          end
          default: state <= PAIR_EVEN;
        endcase
      end
    end
  end

endmodule

// File: rtl/yuv2rgb.sv
// Full-range YCbCr to RGB converter with fixed latency and valid/SOL sideband.
// Optional 4:2:2 chroma pairing in front of a two-stage math pipe, followed
// by plain delay registers to reach the configured latency.
module yuv2rgb
  import yuv_pkg::*;
#(
  parameter int C_BPC = 8,
  parameter int C_DLY = 2,
  parameter int C_422 = 0
) (
  input  logic             CLK_I,
  input  logic             RSTN_I,
  input  logic             VALID_I,
  input  logic             SOL_I,
  input  logic [C_BPC-1:0] Y_I,
  input  logic [C_BPC-1:0] U_I,
  input  logic [C_BPC-1:0] V_I,
  output logic             VALID_O,
  output logic             SOL_O,
  output logic [C_BPC-1:0] R_O,
  output logic [C_BPC-1:0] G_O,
  output logic [C_BPC-1:0] B_O
);

  // Intermediate width; needs C_BPC >= 5 for the Y*256 packing below
  localparam int W = 2 * C_BPC + 3;
  localparam logic [C_BPC:0]        OFF_W = (C_BPC + 1)'(yuv_off(C_BPC));
  localparam logic signed [W-1:0]   C_RV  = W'(K_RV);
  localparam logic signed [W-1:0]   C_GU  = W'(K_GU);
  localparam logic signed [W-1:0]   C_GV  = W'(K_GV);
  localparam logic signed [W-1:0]   C_BU  = W'(K_BU);
  localparam logic signed [W-1:0]   RND   = W'(128);

  // Pixel stream entering the math pipe
  logic             m_valid, m_sol;
  logic [C_BPC-1:0] m_y, m_u, m_v;

  if (C_422 != 0) begin : g_pair
    logic unused_v;
    assign unused_v = ^V_I;
    yuv422_pair #(.C_BPC(C_BPC)) u_pair (
      .clk        (CLK_I),
      .rstn       (RSTN_I),
      .pix_valid  (VALID_I),
      .pix_sol    (SOL_I),
      .pix_y      (Y_I),
      .pix_c      (U_I),
      .pair_valid (m_valid),
      .pair_sol   (m_sol),
      .pair_y     (m_y),
      .pair_u     (m_u),
      .pair_v     (m_v)
    );
  end else begin : g_bypass
    assign m_valid = VALID_I;
    assign m_sol   = SOL_I & VALID_I;
    assign m_y     = Y_I;
    assign m_u     = U_I;
    assign m_v     = V_I;
  end

  // Centre chroma and extend everything to the intermediate width
  logic signed [C_BPC:0] u_s, v_s;
  logic signed [W-1:0]   u_w, v_w, y_w;
  assign u_s = $signed({1'b0, m_u} - OFF_W);
  assign v_s = $signed({1'b0, m_v} - OFF_W);
  assign u_w = {{(W - C_BPC - 1){u_s[C_BPC]}}, u_s};
  assign v_w = {{(W - C_BPC - 1){v_s[C_BPC]}}, v_s};
  assign y_w = {{(W - C_BPC - 8){1'b0}}, m_y, 8'd0};

  logic                s1_valid, s1_sol;
  logic signed [W-1:0] s1_y, s1_rv, s1_gu, s1_gv, s1_bu;

  // Stage 1: register the scaled luma and the four chroma products
  always_ff @(posedge CLK_I) begin
    if (!RSTN_I) begin
      s1_valid <= 1'b0;
      s1_sol   <= 1'b0;
      s1_y     <= '0;
      s1_rv    <= '0;
      s1_gu    <= '0;
      s1_gv    <= '0;
      s1_bu    <= '0;
    end else begin
      s1_valid <= m_valid;
      s1_sol   <= m_sol;
      s1_y     <= y_w;
      s1_rv    <= C_RV * v_w;
      s1_gu    <= C_GU * u_w;
      s1_gv    <= C_GV * v_w;
      s1_bu    <= C_BU * u_w;
    end
  end

  // Sum with rounding, arithmetic shift back to component scale, saturate
  logic signed [W-1:0] sum_r, sum_g, sum_b;
  logic [C_BPC-1:0]    r_c, g_c, b_c;
  assign sum_r = s1_y + s1_rv + RND;
  assign sum_g = s1_y - s1_gu - s1_gv + RND;
  assign sum_b = s1_y + s1_bu + RND;
  assign r_c   = C_BPC'(yuv_clamp(int'(sum_r >>> 8), C_BPC));
  assign g_c   = C_BPC'(yuv_clamp(int'(sum_g >>> 8), C_BPC));
  assign b_c   = C_BPC'(yuv_clamp(int'(sum_b >>> 8), C_BPC));

  // Index 0 is the stage-2 register; higher indices are pure delay
  logic             d_valid [0:C_DLY-2];
  logic             d_sol   [0:C_DLY-2];
  logic [C_BPC-1:0] d_r     [0:C_DLY-2];
  logic [C_BPC-1:0] d_g     [0:C_DLY-2];
  logic [C_BPC-1:0] d_b     [0:C_DLY-2];

  // Stage 2 result register followed by the delay chain
  always_ff @(posedge CLK_I) begin
    if (!RSTN_I) begin
      for (int i = 0; i < C_DLY - 1; i++) begin
        d_valid[i] <= 1'b0;
        d_sol[i]   <= 1'b0;
        d_r[i]     <= '0;
        d_g[i]     <= '0;
        d_b[i]     <= '0;
      end
    end else begin
      d_valid[0] <= s1_valid;
      d_sol[0]   <= s1_sol;
      d_r[0]     <= r_c;
      d_g[0]     <= g_c;
      d_b[0]     <= b_c;
      for (int i = 1; i < C_DLY - 1; i++) begin
        d_valid[i] <= d_valid[i-1];
        d_sol[i]   <= d_sol[i-1];
        d_r[i]     <= d_r[i-1];
        d_g[i]     <= d_g[i-1];
        d_b[i]     <= d_b[i-1];
      end
    end
  end

  assign VALID_O = d_valid[C_DLY-2];
  assign SOL_O   = d_sol[C_DLY-2];
  assign R_O     = d_r[C_DLY-2];
  assign G_O     = d_g[C_DLY-2];
  assign B_O     = d_b[C_DLY-2];

endmodule

// File: tb/tb_yuv2rgb.sv
// Scoreboard bench for yuv2rgb: one 4:4:4 instance (latency 2) and two 4:2:2
// instances (latency 2 and 4) sharing a directed 4:2:2 stream.
module tb_yuv2rgb;

  typedef struct {
    logic [7:0] r, g, b;
    logic       sol;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  logic in_rst = 1'b0;
  int   checks = 0;
  int   passed = 0;

  exp_t q4[$];
  exp_t qa[$];
  exp_t qb[$];
  exp_t e4, ea, eb;

  // 4:4:4 instance signals
  logic       v4_i, s4_i;
  logic [7:0] y4_i, u4_i, w4_i;
  logic       v4_o, s4_o;
  logic [7:0] r4_o, g4_o, b4_o;

  // 4:2:2 shared stimulus
  logic       vp_i, sp_i;
  logic [7:0] yp_i, cp_i, vpad;

  logic       va_o, sa_o, vb_o, sb_o;
  logic [7:0] ra_o, ga_o, ba_o, rb_o, gb_o, bb_o;

  always #5 clk = ~clk;

  // Cycle counter and reset-sampled flag, both updated on the active edge
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    in_rst <= !rstn;
  end

  yuv2rgb #(.C_BPC(8), .C_DLY(2), .C_422(0)) dut444 (
    .CLK_I(clk), .RSTN_I(rstn), .VALID_I(v4_i), .SOL_I(s4_i),
    .Y_I(y4_i), .U_I(u4_i), .V_I(w4_i),
    .VALID_O(v4_o), .SOL_O(s4_o), .R_O(r4_o), .G_O(g4_o), .B_O(b4_o));

  yuv2rgb #(.C_BPC(8), .C_DLY(2), .C_422(1)) dut422a (
    .CLK_I(clk), .RSTN_I(rstn), .VALID_I(vp_i), .SOL_I(sp_i),
    .Y_I(yp_i), .U_I(cp_i), .V_I(vpad),
    .VALID_O(va_o), .SOL_O(sa_o), .R_O(ra_o), .G_O(ga_o), .B_O(ba_o));

  yuv2rgb #(.C_BPC(8), .C_DLY(4), .C_422(1)) dut422b (
    .CLK_I(clk), .RSTN_I(rstn), .VALID_I(vp_i), .SOL_I(sp_i),
    .Y_I(yp_i), .U_I(cp_i), .V_I(vpad),
    .VALID_O(vb_o), .SOL_O(sb_o), .R_O(rb_o), .G_O(gb_o), .B_O(bb_o));

  task automatic chk_pix(input string nm, input exp_t e, input logic s,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    checks++;
    if ({r, g, b, s} === {e.r, e.g, e.b, e.sol} && cyc == e.cyc) begin
      passed++;
      $display("[%s] cyc=%0d rgb=(%0d,%0d,%0d) sol=%0d ok", nm, cyc, r, g, b, s);
    end else begin
      $display("FAIL %s: got rgb=(%0d,%0d,%0d) sol=%0d at cyc %0d, expected rgb=(%0d,%0d,%0d) sol=%0d at cyc %0d",
               nm, r, g, b, s, cyc, e.r, e.g, e.b, e.sol, e.cyc);
    end
  endtask

  task automatic chk_zero(input string nm, input logic v, input logic s,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    checks++;
    if ({v, s, r, g, b} === 26'd0)
      passed++;
    else
      $display("FAIL %s reset: got valid=%0d sol=%0d rgb=(%0d,%0d,%0d) at cyc %0d, expected all 0",
               nm, v, s, r, g, b, cyc);
  endtask

  task automatic unexpected(input string nm, input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b);
    checks++;
    $display("FAIL %s: got unexpected pixel rgb=(%0d,%0d,%0d) at cyc %0d, expected no output",
             nm, r, g, b, cyc);
  endtask

  // Monitor for the 4:4:4 instance
  always @(negedge clk) begin
    if (in_rst) chk_zero("o444", v4_o, s4_o, r4_o, g4_o, b4_o);
    else if (v4_o === 1'b1) begin
      if (q4.size() == 0) unexpected("o444", r4_o, g4_o, b4_o);
      else begin
        e4 = q4.pop_front();
        chk_pix("o444", e4, s4_o, r4_o, g4_o, b4_o);
      end
    end
  end

  // Monitor for the 4:2:2 latency-2 instance
  always @(negedge clk) begin
    if (in_rst) chk_zero("o422d2", va_o, sa_o, ra_o, ga_o, ba_o);
    else if (va_o === 1'b1) begin
      if (qa.size() == 0) unexpected("o422d2", ra_o, ga_o, ba_o);
      else begin
        ea = qa.pop_front();
        chk_pix("o422d2", ea, sa_o, ra_o, ga_o, ba_o);
      end
    end
  end

  // Monitor for the 4:2:2 latency-4 instance
  always @(negedge clk) begin
    if (in_rst) chk_zero("o422d4", vb_o, sb_o, rb_o, gb_o, bb_o);
    else if (vb_o === 1'b1) begin
      if (qb.size() == 0) unexpected("o422d4", rb_o, gb_o, bb_o);
      else begin
        eb = qb.pop_front();
        chk_pix("o422d4", eb, sb_o, rb_o, gb_o, bb_o);
      end
    end
  end

  // One 4:4:4 pixel; output due C_DLY=2 cycles later
  task automatic drive444(input logic s, input logic [7:0] y, input logic [7:0] u,
                          input logic [7:0] v, input logic [7:0] er, input logic [7:0] eg,
                          input logic [7:0] eb);
    v4_i = 1'b1; s4_i = s; y4_i = y; u4_i = u; w4_i = v;
    q4.push_back('{er, eg, eb, s, cyc + 2});
    @(negedge clk);
    v4_i = 1'b0; s4_i = 1'b0;
  endtask

  // Expected pixel k (0 or 1) of a pair whose Cr/SOL input is driven this cycle
  task automatic push422(input int k, input logic s, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b);
    qa.push_back('{r, g, b, s, cyc + 3 + k});
    qb.push_back('{r, g, b, s, cyc + 5 + k});
  endtask

  task automatic send422(input logic s, input logic [7:0] y, input logic [7:0] c);
    vp_i = 1'b1; sp_i = s; yp_i = y; cp_i = c;
    @(negedge clk);
    vp_i = 1'b0; sp_i = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    v4_i = 1'b0; s4_i = 1'b0; y4_i = 8'd0; u4_i = 8'd0; w4_i = 8'd0;
    vp_i = 1'b0; sp_i = 1'b0; yp_i = 8'd0; cp_i = 8'd0; vpad = 8'd0;
    gap(4);
    rstn = 1'b1;
    gap(1);

    // 4:4:4 vectors: grey, red, clamp high, clamp low, two mixed colours
    drive444(1'b1, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
    drive444(1'b0, 8'd76,  8'd85,  8'd255, 8'd254, 8'd0,   8'd0);
    drive444(1'b0, 8'd255, 8'd128, 8'd255, 8'd255, 8'd164, 8'd255);
    gap(2);
    drive444(1'b0, 8'd0,   8'd0,   8'd0,   8'd0,   8'd136, 8'd0);
    drive444(1'b0, 8'd200, 8'd50,  8'd90,  8'd147, 8'd254, 8'd62);
    drive444(1'b0, 8'd50,  8'd200, 8'd60,  8'd0,   8'd74,  8'd178);
    gap(4);

    // 4:2:2 line of four greys, back to back
    send422(1'b1, 8'd100, 8'd128);
    push422(0, 1'b1, 8'd100, 8'd100, 8'd100);
    push422(1, 1'b0, 8'd110, 8'd110, 8'd110);
    send422(1'b0, 8'd110, 8'd128);
    send422(1'b0, 8'd120, 8'd128);
    push422(0, 1'b0, 8'd120, 8'd120, 8'd120);
    push422(1, 1'b0, 8'd130, 8'd130, 8'd130);
    send422(1'b0, 8'd130, 8'd128);

    // Odd-length line: third pixel flushed with neutral Cr on next SOL
    send422(1'b1, 8'd60, 8'd128);
    push422(0, 1'b1, 8'd60, 8'd60, 8'd60);
    push422(1, 1'b0, 8'd70, 8'd70, 8'd70);
    send422(1'b0, 8'd70, 8'd128);
    send422(1'b0, 8'd100, 8'd200);
    push422(0, 1'b0, 8'd100, 8'd75, 8'd228);
    send422(1'b1, 8'd80, 8'd128);
    push422(0, 1'b1, 8'd80, 8'd80, 8'd80);
    push422(1, 1'b0, 8'd90, 8'd90, 8'd90);
    send422(1'b0, 8'd90, 8'd128);

    // Line with 1..3 idle cycles between Y0 and Y1
    send422(1'b1, 8'd76, 8'd85);
    gap(1);
    push422(0, 1'b1, 8'd254, 8'd0,   8'd0);
    push422(1, 1'b0, 8'd255, 8'd124, 8'd124);
    send422(1'b0, 8'd200, 8'd255);
    send422(1'b0, 8'd200, 8'd50);
    gap(2);
    push422(0, 1'b0, 8'd147, 8'd254, 8'd62);
    push422(1, 1'b0, 8'd0,   8'd104, 8'd0);
    send422(1'b0, 8'd50, 8'd90);
    send422(1'b0, 8'd128, 8'd128);
    gap(3);
    push422(0, 1'b0, 8'd128, 8'd128, 8'd128);
    push422(1, 1'b0, 8'd255, 8'd255, 8'd255);
    send422(1'b0, 8'd255, 8'd128);
    gap(8);

    // Reset while a Y0 is held; it must never appear
    send422(1'b1, 8'd33, 8'd128);
    gap(1);
    rstn = 1'b0;
    gap(4);
    rstn = 1'b1;
    gap(1);
    send422(1'b1, 8'd40, 8'd128);
    push422(0, 1'b1, 8'd40, 8'd40, 8'd40);
    push422(1, 1'b0, 8'd50, 8'd50, 8'd50);
    send422(1'b0, 8'd50, 8'd128);
    gap(12);

    // Every expected pixel must have been delivered
    checks++;
    if (q4.size() == 0) passed++;
    else $display("FAIL drain444: got %0d pixels still pending, expected 0", q4.size());
    checks++;
    if (qa.size() == 0) passed++;
    else $display("FAIL drain422d2: got %0d pixels still pending, expected 0", qa.size());
    checks++;
    if (qb.size() == 0) passed++;
    else $display("FAIL drain422d4: got %0d pixels still pending, expected 0", qb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/yuv2rgb.md
Name: yuv2rgb

Overview:
- Inverse of the frame-buffer read-path RGB→YUV converter: turns full-range YCbCr (same ×256 fixed-point coefficient family) back into RGB.
- Sits on the frame-buffer write/capture side, ahead of RGB display/test logic.
- Accepts 4:4:4 or 4:2:2 pixel streams and re-pairs chroma in the 4:2:2 case.
- Fixed-latency pipeline with valid/start-of-line sideband; no backpressure.

Parameters:
- C_BPC, 8: bits per component.
- C_DLY, 2: math-pipeline latency in cycles; must be ≥ 2. Extra cycles are pure delay registers.
- C_422, 0: 0 = 4:4:4 input; 1 = 4:2:2 input with Cb/Cr alternating on U_I.

Ports:
- CLK_I  in  1  clock
- RSTN_I  in  1  synchronous reset, active-low
- VALID_I  in  1  input pixel valid
- SOL_I  in  1  first pixel of a line; qualified by VALID_I
- Y_I  in  C_BPC  luma
- U_I  in  C_BPC  Cb (4:4:4); in 4:2:2, Cb on even pixels and Cr on odd pixels
- V_I  in  C_BPC  Cr (4:4:4); ignored in 4:2:2
- VALID_O  out  1  output pixel valid
- SOL_O  out  1  first output pixel of a line
- R_O  out  C_BPC  red
- G_O  out  C_BPC  green
- B_O  out  C_BPC  blue

Behaviour:
- Reset: while RSTN_I=0 at a clock edge, all pipeline and pairing registers clear. VALID_O=0, SOL_O=0, R_O=G_O=B_O=0 from the next cycle. Pairing FSM returns to EVEN and the pending flag clears.
- Reset mid-line: held Y0/Cb is discarded; no output is produced for it.
- Arithmetic:
  - OFF = 1<<(C_BPC-1); u = U-OFF, v = V-OFF (signed, C_BPC+1 bits).
  - R = clamp((Y·256 + 359·v + 128) >>> 8)
  - G = clamp((Y·256 − 88·u − 183·v + 128) >>> 8)
  - B = clamp((Y·256 + 454·u + 128) >>> 8)
  - Signed intermediates of at least 2·C_BPC+3 bits. clamp maps <0 to 0 and >2^C_BPC−1 to all-ones.
- Math pipeline:
  - Stage 1 registers products and Y·256.
  - Stage 2 registers sum, round, shift and clamp.
  - C_DLY−2 further delay registers follow, also cleared by reset.
  - VALID and SOL travel alongside the data with identical delay.
- 4:4:4 (C_422=0): pairing bypassed. VALID_O/SOL_O/RGB appear exactly C_DLY cycles after VALID_I/SOL_I.
- 4:2:2 (C_422=1): registered pairing stage in front of the math pipe.
  - State EVEN, valid input: latch Y0 and Cb; go to ODD; latch SOL_I as sol0.
  - State ODD, valid input (SOL_I=0): this is Y1 with Cr.
    - Next cycle, issue pixel0 (Y0, Cb, Cr, sol0) into the math pipe.
    - Set pend with Y1, Cb, Cr; go to EVEN.
  - pend=1: pixel1 is issued the cycle after pixel0, unconditionally. pend clears.
  - A new Y0 accepted in the same cycle is latched normally; no collision is possible.
- 4:2:2 latency: pixel0 emerges C_DLY+1 cycles after the Cr input cycle; pixel1 one cycle later. Gaps in VALID_I only delay the pairing.
- 4:2:2 boundary, SOL_I while ODD (odd-length line):
  - Held Y0 is issued with Cb and Cr=OFF (neutral).
  - The SOL pixel is latched as the new Y0/Cb; state stays ODD.
- 4:2:2 boundary: VALID_I=0 cycles leave the FSM unchanged. SOL_I without VALID_I is ignored.
- Throughput: one pixel per cycle sustained in both modes.

Decomposition:
- Shared package yuv_pkg holds the coefficient constants: Y→RGB set 359/88/183/454 and the RGB→YUV set 77/150/29, 43/85/128, 128/107/21.
- yuv_pkg also holds the OFF function and a clamp function parameterised on C_BPC.
- One natural sub-module: yuv422_pair, containing the pairing FSM plus pend register. It is instantiated only when C_422=1.
- Math pipeline and delay chain stay in yuv2rgb.

Test Plan:
- 4:4:4, C_BPC=8, C_DLY=2: Y=U=V=128 with VALID_I → RGB=(128,128,128), VALID_O exactly 2 cycles later.
- 4:4:4 red: Y=76, U=85, V=255 → (254,0,0). Y=255, V=255 → R=255 (clamp high). Y=0, U=V=0 → R=0, B=0 (clamp low).
- 4:2:2 line of 4 pixels, SOL on first:
  - Input Y=(100,110,120,130), chroma Cb0=128, Cr0=128, Cb1=128, Cr1=128.
  - Expect greys 100,110,120,130 in order.
  - SOL_O on the first pixel only.
  - First output C_DLY+1 cycles after the second input.
- 4:2:2 odd-length line:
  - 3-pixel line then SOL_I.
  - Third pixel is emitted with Cr=128.
  - Next line pairs correctly; no dropped or duplicated pixels.
- 4:2:2 with VALID_I gaps of 1–3 cycles between Y0 and Y1: outputs are identical to the gapless stream, only shifted in time.
- RSTN_I low while ODD, then release and send a fresh line: all outputs 0 during reset, no stale pixel emitted, fresh line correct; sweep C_DLY=2 and C_DLY=4.
